// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, ALU-issue and response bundle of the alu_sched block.
// Latency: pure wiring, none.
// Backpressure: requests use req_valid/req_ready; ALU results and responses cannot be stalled.
interface alu_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2;
  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          alu_valid_o;
  logic [DATA_WIDTH-1:0]         alu_data_1_o;
  logic [DATA_WIDTH-1:0]         alu_data_2_o;
  logic [SEL_WIDTH-1:0]          alu_sel_o;
  logic                          alu_valid_i;
  logic [2*DATA_WIDTH-1:0]       alu_data_i;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [2*DATA_WIDTH-1:0]       rsp_data;
  logic                          busy_o;
  logic                          err_o;

  // Environment side: requesters plus the shared ALU.
  modport master (
    output req_valid, req_data_1, req_data_2, req_sel, alu_valid_i, alu_data_i,
    input  req_ready, alu_valid_o, alu_data_1_o, alu_data_2_o, alu_sel_o,
    input  rsp_valid, rsp_data, busy_o, err_o
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data_1, req_data_2, req_sel, alu_valid_i, alu_data_i,
    output req_ready, alu_valid_o, alu_data_1_o, alu_data_2_o, alu_sel_o,
    output rsp_valid, rsp_data, busy_o, err_o
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin issue of NUM_REQ requesters onto one shared ALU, results routed back by tag.
// Latency: grant combinational; alu_valid_o 1 cycle after handshake; rsp_valid 1 cycle after ALU valid.
// Backpressure: one grant per cycle via req_ready; responses cannot be stalled; mismatched ALU valids set err_o.
module alu_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int NUM_REQ    = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  alu_sched_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int MASK_W = $clog2(ALU_LAT + 2);
  localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(ALU_LAT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  // Arbitration
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             xfer;
  int               cand;

  // Issue register
  logic                  alu_vld_q, alu_vld_d;
  logic [DATA_WIDTH-1:0] alu_d1_q, alu_d1_d;
  logic [DATA_WIDTH-1:0] alu_d2_q, alu_d2_d;
  logic [SEL_WIDTH-1:0]  alu_sel_q, alu_sel_d;
  logic [IDX_W-1:0]      iss_idx_q, iss_idx_d;

  // Tag pipeline: stage 0 in the low bits, output stage in the high bits
  logic [ALU_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [ALU_LAT*IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic [ALU_LAT:0]           tag_vld_sh;
  logic [(ALU_LAT+1)*IDX_W-1:0] tag_idx_sh;
  logic                       tag_out_vld;
  logic [IDX_W-1:0]           tag_out_idx;

  // Response, status and post-reset mask
  logic [NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;
  logic [2*DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [MASK_W-1:0]       mask_q, mask_d;
  logic                    masked, hit;

  // Pick the first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    // Descending scan so the lowest offset from ptr is the last (winning) match.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  assign xfer          = gnt_any & ~rst;
  assign bus.req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign tag_out_vld = tag_vld_q[ALU_LAT-1];
  assign tag_out_idx = tag_idx_q[ALU_LAT*IDX_W-1 -: IDX_W];
  // Late ALU valids from operations dropped by a reset must not raise errors.
  assign masked      = (mask_q != '0);
  assign hit         = tag_out_vld & bus.alu_valid_i & ~masked;

  // Next-state logic for issue, tag shift, response, error and busy.
  always_comb begin
    ptr_d     = ptr_q;
    alu_vld_d = xfer;
    alu_d1_d  = alu_d1_q;
    alu_d2_d  = alu_d2_q;
    alu_sel_d = alu_sel_q;
    iss_idx_d = iss_idx_q;
    rsp_vld_d = '0;
    rsp_dat_d = rsp_dat_q;
    err_d     = err_q;
    mask_d    = masked ? (mask_q - 1'b1) : mask_q;

    if (xfer) begin
      ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      alu_d1_d  = bus.req_data_1[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      alu_d2_d  = bus.req_data_2[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      alu_sel_d = bus.req_sel[gnt_idx*SEL_WIDTH +: SEL_WIDTH];
      iss_idx_d = gnt_idx;
    end

    // Stage 0 follows the issue register; the oldest stage falls off the top.
    tag_vld_sh = {tag_vld_q, alu_vld_q};
    tag_idx_sh = {tag_idx_q, iss_idx_q};
    tag_vld_d  = tag_vld_sh[ALU_LAT-1:0];
    tag_idx_d  = tag_idx_sh[ALU_LAT*IDX_W-1:0];

    if (hit) begin
      rsp_vld_d = NUM_REQ'(1) << tag_out_idx;
      rsp_dat_d = bus.alu_data_i;
    end

    // Missing result or orphan result both count as a sticky error.
    if (!masked && (tag_out_vld != bus.alu_valid_i)) err_d = 1'b1;

    busy_d = alu_vld_d | (|tag_vld_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      alu_vld_q <= 1'b0;
      alu_d1_q  <= '0;
      alu_d2_q  <= '0;
      alu_sel_q <= '0;
      iss_idx_q <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mask_q    <= MASK_INIT;
    end else begin
      ptr_q     <= ptr_d;
      alu_vld_q <= alu_vld_d;
      alu_d1_q  <= alu_d1_d;
      alu_d2_q  <= alu_d2_d;
      alu_sel_q <= alu_sel_d;
      iss_idx_q <= iss_idx_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.alu_valid_o  = alu_vld_q;
  assign bus.alu_data_1_o = alu_d1_q;
  assign bus.alu_data_2_o = alu_d2_q;
  assign bus.alu_sel_o    = alu_sel_q;
  assign bus.rsp_valid    = rsp_vld_q;
  assign bus.rsp_data     = rsp_dat_q;
  assign bus.busy_o       = busy_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed vectors against alu_sched with a two-stage behavioural ALU.
// Latency: checks land on the cycle numbers the scheduler promises (grant t, ALU t+3, response t+4).
// Backpressure: kill/inject overrides on the ALU valid exercise the error paths.
`timescale 1ns/1ps
module tb_alu_sched;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int NR  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic        kill   = 1'b0;
  logic        inject = 1'b0;
  logic        mdl_v0 = 1'b0;
  logic        mdl_v1 = 1'b0;
  logic [15:0] mdl_d0 = '0;
  logic [15:0] mdl_d1 = '0;

  logic [3:0]  sk_exp [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001};
  logic [15:0] op_exp [3] = '{16'h00fe, 16'h0080, 16'h0000};

  alu_sched_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .NUM_REQ(NR)) io ();

  alu_sched #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .NUM_REQ(NR), .ALU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 0 add, 1 subtract, 2 increment operand 1, 3 returns zero.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return {8'h00, a} + {8'h00, b};
      2'd1:    return {8'h00, a - b};
      2'd2:    return {8'h00, a} + 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // Two-stage ALU pipe, deliberately not reset so late results survive a scheduler reset.
  always @(posedge clk) begin
    mdl_v0 <= io.alu_valid_o;
    mdl_d0 <= alu_fn(io.alu_data_1_o, io.alu_data_2_o, io.alu_sel_o);
    mdl_v1 <= mdl_v0;
    mdl_d1 <= mdl_d0;
  end

  assign io.alu_valid_i = (mdl_v1 & ~kill) | inject;
  assign io.alu_data_i  = mdl_d1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    io.req_data_1[i*DW +: DW] = a;
    io.req_data_2[i*DW +: DW] = b;
    io.req_sel[i*SW +: SW]    = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.req_valid  = 4'b1111;
    io.req_data_1 = '0;
    io.req_data_2 = '0;
    io.req_sel    = '0;

    // Reset state, with every requester asking during reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",    io.req_ready,    0);
    check("rst_alu_vld",  io.alu_valid_o,  0);
    check("rst_alu_d1",   io.alu_data_1_o, 0);
    check("rst_alu_d2",   io.alu_data_2_o, 0);
    check("rst_alu_sel",  io.alu_sel_o,    0);
    check("rst_rsp_vld",  io.rsp_valid,    0);
    check("rst_rsp_data", io.rsp_data,     0);
    check("rst_busy",     io.busy_o,       0);
    check("rst_err",      io.err_o,        0);
    rst = 1'b0;
    io.req_valid = '0;
    repeat (LAT + 2) @(negedge clk);

    // Single request from requester 0: 05 + 03.
    set_req(0, 8'h05, 8'h03, 2'd0);
    io.req_valid = 4'b0001;
    #1 check("t1_ready", io.req_ready, 4'b0001);
    @(negedge clk);
    io.req_valid = '0;
    #1;
    check("t1_alu_vld", io.alu_valid_o,  1);
    check("t1_alu_d1",  io.alu_data_1_o, 8'h05);
    check("t1_alu_d2",  io.alu_data_2_o, 8'h03);
    check("t1_busy",    io.busy_o,       1);
    repeat (2) @(negedge clk);
    #1 check("t1_rsp_early", io.rsp_valid, 0);
    @(negedge clk);
    #1;
    check("t1_rsp_vld",  io.rsp_valid, 4'b0001);
    check("t1_rsp_data", io.rsp_data,  16'h0008);
    check("t1_err",      io.err_o,     0);
    @(negedge clk);
    #1;
    check("t1_rsp_clr", io.rsp_valid, 0);
    check("t1_idle",    io.busy_o,    0);

    // Round-robin with all four requesters held valid for 8 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 8'(i + 1), 8'h10, 2'd0);
    for (int k = 0; k < 12; k++) begin
      io.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check($sformatf("rr_gnt%0d", k), io.req_ready, 1 << (k % 4));
      if (k >= 4) begin
        check($sformatf("rr_rsp%0d", k - 4), io.rsp_valid, 1 << ((k - 4) % 4));
        check($sformatf("rr_dat%0d", k - 4), io.rsp_data, 16'h0011 + ((k - 4) % 4));
      end
      @(negedge clk);
    end
    check("rr_err", io.err_o, 0);

    // Skip and wrap: 1010 alternates 1,3; then 0001 after the grant to 3.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      io.req_valid = (k < 4) ? 4'b1010 : 4'b0001;
      #1 check($sformatf("sk_gnt%0d", k), io.req_ready, sk_exp[k]);
      @(negedge clk);
    end
    io.req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    check("sk_err",  io.err_o,  0);
    check("sk_busy", io.busy_o, 0);

    // Opcodes back-to-back from requester 2, including sel=3.
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin set_req(2, 8'hff, 8'h01, 2'd1); io.req_valid = 4'b0100; end
        1: set_req(2, 8'h7f, 8'h01, 2'd2);
        2: set_req(2, 8'h12, 8'h34, 2'd3);
        default: io.req_valid = '0;
      endcase
      #1;
      if (k < 3) check($sformatf("op_gnt%0d", k), io.req_ready, 4'b0100);
      if (k == 3) check("op_sel3_fwd", io.alu_sel_o, 2'd3);
      if (k >= 4 && k < 7) begin
        check($sformatf("op_rsp%0d", k - 4), io.rsp_valid, 4'b0100);
        check($sformatf("op_dat%0d", k - 4), io.rsp_data, op_exp[k-4]);
      end
      @(negedge clk);
    end

    // Missing ALU valid, then an orphan ALU valid.
    do_reset();
    set_req(0, 8'h01, 8'h01, 2'd0);
    io.req_valid = 4'b0001;
    @(negedge clk);
    io.req_valid = '0;
    repeat (2) @(negedge clk);
    kill = 1'b1;
    #1 check("er_err_pre", io.err_o, 0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("er_miss_rsp", io.rsp_valid, 0);
    check("er_miss_err", io.err_o,     1);
    @(negedge clk);
    #1 check("er_sticky", io.err_o, 1);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    check("er_orph_rsp", io.rsp_valid, 0);
    check("er_orph_err", io.err_o,     1);
    do_reset();
    #1 check("er_clr", io.err_o, 0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    check("er_orph2_rsp", io.rsp_valid, 0);
    check("er_orph2_err", io.err_o,     1);

    // Reset with three operations in flight; late ALU valids must be ignored.
    do_reset();
    set_req(1, 8'h02, 8'h03, 2'd0);
    io.req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    io.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 4; k < 10; k++) begin
      #1;
      check($sformatf("rm_rsp%0d", k),  io.rsp_valid, 0);
      check($sformatf("rm_busy%0d", k), io.busy_o,    0);
      check($sformatf("rm_err%0d", k),  io.err_o,     0);
      @(negedge clk);
    end
    io.req_valid = 4'b1111;
    #1 check("rm_first_gnt", io.req_ready, 4'b0001);
    @(negedge clk);
    io.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one `alu` instance among `NUM_REQ` requesters. It sits between the requesters and the ALU's `valid_i`/`data_i_*`/`sel_i` inputs, issuing at most one operation per cycle. It tracks the requester that owns each in-flight operation and routes every ALU result back to that requester. It also flags any ALU valid that does not line up with an issued operation.

## Interface
- `DATA_WIDTH`, 8, operand width; the result is 2*DATA_WIDTH.
- `SEL_WIDTH`, 2, opcode width.
- `NUM_REQ`, 4, number of requesters (2..16).
- `ALU_LAT`, 2, cycles from `alu_valid_o` high to the matching `alu_valid_i` high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester operation request.
- `req_data_1` in NUM_REQ*DATA_WIDTH: packed operand 1; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_data_2` in NUM_REQ*DATA_WIDTH: packed operand 2, same slicing.
- `req_sel` in NUM_REQ*SEL_WIDTH: packed opcodes, same slicing.
- `req_ready` out NUM_REQ: one-hot grant; combinational from `req_valid` and the priority pointer.
- `alu_valid_o` out 1: drives the ALU `valid_i`.
- `alu_data_1_o` out DATA_WIDTH: drives ALU `data_i_1`.
- `alu_data_2_o` out DATA_WIDTH: drives ALU `data_i_2`.
- `alu_sel_o` out SEL_WIDTH: drives ALU `sel_i`.
- `alu_valid_i` in 1: ALU `valid_o`.
- `alu_data_i` in 2*DATA_WIDTH: ALU `data_o`.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle result strobe.
- `rsp_data` out 2*DATA_WIDTH: result; meaningful only while `rsp_valid` is non-zero.
- `busy_o` out 1: high while any issued operation has not yet returned.
- `err_o` out 1: sticky error flag; cleared only by `rst`.

## Operation
- **Arbitration**
  - `ptr` (log2 NUM_REQ bits) is the highest-priority index.
  - The grant goes to the first i with `req_valid[i]=1`, searching `ptr`, `ptr`+1, … modulo NUM_REQ.
  - `req_ready[i]` is high only for the granted index, and only when some `req_valid` bit is high.
- **Handshake**
  - A transfer happens when `req_valid[i] & req_ready[i]`.
  - On a transfer, `ptr` becomes i+1, wrapping from NUM_REQ-1 to 0.
  - With no request, `ptr` holds its value.
  - No transfer occurs in the cycle `rst` is high; `req_ready` is all-zero during reset.
- **Issue register**
  - On a transfer, the granted operands and opcode are registered onto `alu_*_o`, and `alu_valid_o`=1 in the next cycle.
  - Otherwise `alu_valid_o`=0, and the `alu_data_*_o`/`alu_sel_o` registers hold their values.
  - Opcodes are forwarded unchanged, including `sel`=3; the ALU returns 0 for that opcode, and the scheduler routes that 0 normally.
- **Tag pipeline**
  - An ALU_LAT-deep shift register carries {tag_valid, tag_idx}.
  - Stage 0 is loaded with {`alu_valid_o`, granted index} in step with the issue register.
  - The output stage is compared against `alu_valid_i` each cycle.
- **Response**
  - When the output-stage tag is valid and `alu_valid_i`=1:
    - `rsp_valid[tag_idx]` pulses one cycle later.
    - `rsp_data` carries the registered `alu_data_i`.
  - Requesters cannot backpressure responses.
- **Error**
  - A tag is valid but `alu_valid_i`=0: set `err_o` and produce no response.
  - `alu_valid_i`=1 with no valid tag: set `err_o` and discard the data.
- **`busy_o`**
  - High when `alu_valid_o` is high or any tag stage is valid.

## Timing
- Throughput: one transfer per cycle, sustained back-to-back, including from the same requester.
- Latency, handshake edge at cycle t:
  - `alu_valid_o` high in t+1.
  - `alu_valid_i` expected in t+1+ALU_LAT (t+3 by default).
  - `rsp_valid` high in t+2+ALU_LAT (t+4 by default).
- Fairness: a continuously asserted `req_valid[i]` is granted within NUM_REQ cycles.
- All-requesters-valid: grants rotate 0, 1, …, NUM_REQ-1, 0, … starting from `ptr` after reset.
- Reset values:
  - `ptr`=0 and every tag stage invalid.
  - `alu_valid_o`=0, `alu_data_1_o`=0, `alu_data_2_o`=0, `alu_sel_o`=0.
  - `rsp_valid`=0, `rsp_data`=0, `busy_o`=0, `err_o`=0.
- Reset during in-flight operations:
  - All tags are dropped.
  - ALU valids arriving within ALU_LAT+1 cycles after `rst` deasserts are ignored and do not set `err_o`.
  - Implement this with a post-reset mask counter.
- `rsp_data` is a registered output; `req_ready` is the only combinational output.

## Test plan
- **Single request.** After reset, `req_valid`=0001 with data_1=8'h05, data_2=8'h03, sel=0.
  - `req_ready`=0001 in the same cycle.
  - `alu_valid_o`=1 with operands 05/03 in t+1.
  - `rsp_valid`=0001 with `rsp_data`=16'h0008 in t+4; `err_o`=0.
- **Round-robin.** Hold `req_valid`=1111 for 8 cycles.
  - Grant sequence is 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order, each 4 cycles after its grant.
- **Skip and wrap.** `req_valid`=1010 held, `ptr`=0 after reset.
  - Grants alternate 1,3,1,3.
  - Drop to `req_valid`=0001 after a grant to 3: the next grant is 0.
- **Opcodes.** Requester 2 issues sel=1 with ff/01, then sel=2 with 8'h7f, then sel=3.
  - `rsp_data`=16'h00fe, then 16'h0080, then 16'h0000, all with `rsp_valid`=0100.
- **Error detection.**
  - Force `alu_valid_i`=0 where a result is due: no `rsp_valid`, and `err_o` rises one cycle later and stays high.
  - Then pulse `alu_valid_i` with an empty tag pipe: `err_o` stays 1 and there is no response.
- **Reset mid-flight.** Issue three operations, assert `rst` one cycle after the third transfer, and let the ALU return late valids.
  - `rsp_valid`, `busy_o` and `err_o` stay 0.
  - The first post-reset grant goes to requester 0 when `req_valid`=1111.
